// File: rtl/chip8_pkg.sv
// chip8_pkg: shared CHIP-8 scalar types, reset PC and fetch FSM states
package chip8_pkg;
  typedef logic [3:0]  u4;
  typedef logic [7:0]  u8;
  typedef logic [11:0] u12;
  typedef logic [15:0] u16;
  localparam u12 RESET_PC_DEFAULT = 12'h200;
  typedef enum logic [1:0] {S_HI, S_LO, S_CAP, S_HOLD} fetch_state_t;
endpackage

// File: rtl/chip8_fetch.sv
// chip8_fetch: program counter and two-byte big-endian instruction fetch with valid/ready and redirects
module chip8_fetch
  import chip8_pkg::*;
#(
  parameter int                ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  u8                 mem_rdata,
  output u16                instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_addr,
  input  logic              pc_skip
);
  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  u8                 hi;
  // The read strobe is decoded from the state so the byte lands in the very next state.
  always_comb begin
    mem_rd   = rst && (state == S_LO || (state == S_HI && fetch_en));
    mem_addr = mem_rd ? (state == S_LO ? pc + ADDR_W'(1) : pc) : '0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_HI;
      pc          <= RESET_PC;
      hi          <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else if (pc_load || pc_skip) begin
      pc          <= pc_load ? pc_load_addr : pc + ADDR_W'(2);
      instr_valid <= 1'b0;
      state       <= S_HI;
    end else begin
      case (state)
        S_HI:   state <= fetch_en ? S_LO : S_HI;
        S_LO: begin
          hi    <= mem_rdata;
          state <= S_CAP;
        end
        S_CAP: begin
          instr       <= {hi, mem_rdata};
          instr_pc    <= pc;
          pc          <= pc + ADDR_W'(2);
          instr_valid <= 1'b1;
          state       <= S_HOLD;
        end
        S_HOLD: if (instr_ready) begin
          instr_valid <= 1'b0;
          state       <= S_HI;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_chip8_fetch.sv
// tb_chip8_fetch: scoreboard bench for chip8_fetch with a byte-wide memory model
module tb_chip8_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic [11:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata = '0;
  logic [15:0] instr;
  logic [11:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        pc_load;
  logic [11:0] pc_load_addr;
  logic        pc_skip;
  logic [7:0]  mem [4096];
  logic [27:0] sb [$];
  int          n_cmp = 0;
  int          n_bad = 0;

  chip8_fetch dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .pc_load(pc_load), .pc_load_addr(pc_load_addr), .pc_skip(pc_skip)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst && instr_valid && instr_ready) begin
      if (sb.size() == 0) check("unexpected_valid", 32'(instr_valid), 32'd0);
      else begin
        logic [27:0] e;
        e = sb.pop_front();
        check("instr_pc", 32'(instr_pc), 32'(e[27:16]));
        check("instr", 32'(instr), 32'(e[15:0]));
      end
    end
  end

  task automatic expect_at(input logic [11:0] a);
    logic [11:0] b;
    b = a + 12'd1;
    sb.push_back({a, mem[a], mem[b]});
  endtask

  task automatic redirect(input logic ld, input logic sk, input logic [11:0] a);
    pc_load = ld;
    pc_skip = sk;
    pc_load_addr = a;
    tick;
    pc_load = 1'b0;
    pc_skip = 1'b0;
  endtask

  task automatic fetch_one(input logic [11:0] a, input logic skip_hs);
    logic [11:0] b;
    b = a + 12'd1;
    fetch_en = 1'b1;
    expect_at(a);
    #1;
    check("hi_rd", 32'(mem_rd), 32'd1);
    check("hi_addr", 32'(mem_addr), 32'(a));
    tick;
    fetch_en = 1'b0;
    check("lo_rd_addr", {19'd0, mem_rd, mem_addr}, {19'd0, 1'b1, b});
    tick;
    check("cap_valid", 32'(instr_valid), 32'd0);
    tick;
    check("hold_valid", 32'(instr_valid), 32'd1);
    check("hold_rd", 32'(mem_rd), 32'd0);
    pc_skip = skip_hs;
    tick;
    pc_skip = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd"}, 32'(mem_rd), 32'd0);
    check({tag, "_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_instr"}, 32'(instr), 32'd0);
    check({tag, "_ipc"}, 32'(instr_pc), 32'd0);
    check({tag, "_valid"}, 32'(instr_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i * 7 + 3) ^ 8'(i >> 4) | 8'h01;
    mem[12'h200] = 8'h00;
    mem[12'h201] = 8'hE0;
    rst = 1'b0;
    fetch_en = 1'b0;
    instr_ready = 1'b1;
    pc_load = 1'b0;
    pc_load_addr = '0;
    pc_skip = 1'b0;
    repeat (2) tick;
    check_reset_outputs("reset");
    rst = 1'b1;
    fetch_one(12'h200, 1'b0);
    check("idle_rd", 32'(mem_rd), 32'd0);
    instr_ready = 1'b0;
    fetch_en = 1'b1;
    expect_at(12'h202);
    #1;
    check("stall_hi_addr", 32'(mem_addr), 32'h202);
    tick;
    fetch_en = 1'b0;
    repeat (2) tick;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(instr_valid), 32'd1);
      check("stall_instr", 32'(instr), {16'd0, mem[12'h202], mem[12'h203]});
      check("stall_ipc", 32'(instr_pc), 32'h202);
      check("stall_rd", 32'(mem_rd), 32'd0);
      tick;
    end
    instr_ready = 1'b1;
    tick;
    check("stall_release", 32'(instr_valid), 32'd0);
    fetch_en = 1'b1;
    tick;
    fetch_en = 1'b0;
    redirect(1'b1, 1'b0, 12'h345);
    for (int i = 0; i < 3; i++) begin
      check("abandon_valid", 32'(instr_valid), 32'd0);
      tick;
    end
    fetch_one(12'h345, 1'b0);
    redirect(1'b1, 1'b1, 12'h345);
    fetch_one(12'h345, 1'b0);
    redirect(1'b1, 1'b0, 12'h210);
    fetch_one(12'h210, 1'b0);
    redirect(1'b0, 1'b1, 12'h000);
    fetch_one(12'h214, 1'b1);
    fetch_one(12'h218, 1'b0);
    redirect(1'b1, 1'b0, 12'hFFF);
    fetch_one(12'hFFF, 1'b0);
    fetch_one(12'h001, 1'b0);
    fetch_en = 1'b1;
    tick;
    fetch_en = 1'b0;
    tick;
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("post_rst_rd", 32'(mem_rd), 32'd0);
      check("post_rst_valid", 32'(instr_valid), 32'd0);
    end
    fetch_one(12'h200, 1'b0);
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
